// File: rtl/mc_core_if.sv
// Memory bus between mc_core (master) and the platform memory system (slave).
// Request/ready handshake: a transaction completes on the edge where mem_req & mem_ready.
interface mc_core_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: register file, ALU, datapath and control FSM with a
// req/ready memory port, zero-extending ori, a GPIO-read instruction and a halt state.
module mc_core #(
  parameter int               WIDTH      = 32,
  parameter int               GPIO_WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  mc_core_if.master             bus,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0]      alu_o,
  output logic [WIDTH-1:0]      pc_o,
  output logic [3:0]            state_o,
  output logic                  halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_GPIOWB = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_IN   = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] mdr_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] alu_reg;
  logic [WIDTH-1:0] rf_reg [32];

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] alu_res;
  logic             funct_ok;
  state_t           dispatch;

  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign imm_sext = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};
  assign imm_zext = {{(WIDTH-16){1'b0}}, ir_reg[15:0]};

  // Decode and R-type ALU; unlisted funct codes are caught in DECODE and halt.
  always_comb begin
    funct_ok = 1'b0;
    alu_res  = '0;
    case (funct)
      FN_ADD: begin funct_ok = 1'b1; alu_res = a_reg + b_reg; end
      FN_SUB: begin funct_ok = 1'b1; alu_res = a_reg - b_reg; end
      FN_AND: begin funct_ok = 1'b1; alu_res = a_reg & b_reg; end
      FN_OR:  begin funct_ok = 1'b1; alu_res = a_reg | b_reg; end
      FN_SLT: begin
        funct_ok = 1'b1;
        alu_res  = ($signed(a_reg) < $signed(b_reg)) ? WIDTH'(1) : '0;
      end
      default: begin funct_ok = 1'b0; alu_res = '0; end
    endcase

    dispatch = S_HALT;
    case (op)
      OP_LW, OP_SW:    dispatch = S_MEMADR;
      OP_R:            dispatch = funct_ok ? S_EXEC : S_HALT;
      OP_BEQ:          dispatch = S_BRANCH;
      OP_ADDI, OP_ORI: dispatch = S_IMMEX;
      OP_J:            dispatch = S_JUMP;
      OP_IN:           dispatch = S_GPIOWB;
      default:         dispatch = S_HALT;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_reg)
      S_MEMWB:  begin wr_en = 1'b1; wr_addr = rt; wr_data = mdr_reg; end
      S_ALUWB:  begin wr_en = 1'b1; wr_addr = rd; wr_data = alu_reg; end
      S_IMMWB:  begin wr_en = 1'b1; wr_addr = rt; wr_data = alu_reg; end
      S_GPIOWB: begin wr_en = 1'b1; wr_addr = rt; wr_data = WIDTH'(gpio_i); end
      default:  begin wr_en = 1'b0; wr_addr = '0; wr_data = '0; end
    endcase
  end

  // Entry 0 is never written, so r0 reads as zero without a read-side mux.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset) begin
          rf_reg[gi] <= '0;
        end else if (gi != 0 && wr_en && wr_addr == 5'(gi)) begin
          rf_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_reg   <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir_reg    <= bus.mem_rdata;
            pc_reg    <= pc_reg + WIDTH'(4);
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg     <= rf_reg[rs];
          b_reg     <= rf_reg[rt];
          alu_reg   <= pc_reg + {imm_sext[WIDTH-3:0], 2'b00};
          state_reg <= dispatch;
        end
        S_MEMADR: begin
          alu_reg   <= a_reg + imm_sext;
          state_reg <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          if (bus.mem_ready) begin
            mdr_reg   <= bus.mem_rdata;
            state_reg <= S_MEMWB;
          end
        end
        S_MEMWB: state_reg <= S_FETCH;
        S_MEMWR: begin
          if (bus.mem_ready) state_reg <= S_FETCH;
        end
        S_EXEC: begin
          alu_reg   <= alu_res;
          state_reg <= S_ALUWB;
        end
        S_ALUWB: state_reg <= S_FETCH;
        S_BRANCH: begin
          if (a_reg == b_reg) pc_reg <= alu_reg;
          state_reg <= S_FETCH;
        end
        S_IMMEX: begin
          alu_reg   <= (op == OP_ORI) ? (a_reg | imm_zext) : (a_reg + imm_sext);
          state_reg <= S_IMMWB;
        end
        S_IMMWB: state_reg <= S_FETCH;
        S_JUMP: begin
          pc_reg    <= {pc_reg[WIDTH-1:28], ir_reg[25:0], 2'b00};
          state_reg <= S_FETCH;
        end
        S_GPIOWB: state_reg <= S_FETCH;
        S_HALT:   state_reg <= S_HALT;
        default:  state_reg <= S_HALT;
      endcase
    end
  end

  // Bus outputs decode the registered state; reset masks them in the reset cycle itself.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = pc_reg;
        end
        S_MEMRD: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = alu_reg;
        end
        S_MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = alu_reg;
          bus.mem_wdata = b_reg;
        end
        default: begin
          bus.mem_req = 1'b0;
        end
      endcase
    end
  end

  assign alu_o   = alu_reg;
  assign pc_o    = pc_reg;
  assign state_o = state_reg;
  assign halted  = (state_reg == S_HALT);

endmodule

// File: doc/mc_core.md
# mc_core

Multicycle MIPS-subset core for the FPGA platform: datapath, register file, ALU and the control FSM in one parametrised block. Successor to the fixed-width multicycle datapath that needs an external controller. Adds four things:
- an internal controller;
- a req/ready memory handshake with wait states;
- a zero-extending `ori`;
- a dedicated GPIO-read instruction and a halt state.

Sits between the platform memory system and the top-level wrapper.

## Interface

Parameters:
- WIDTH, 32, datapath/register/address width; must be ≥ 32.
- GPIO_WIDTH, 16, width of gpio_i; must be ≤ WIDTH.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- mem_req, out, 1, memory transaction request.
- mem_we, out, 1, 1 = write, 0 = read; valid while mem_req=1.
- mem_addr, out, WIDTH, byte address, word aligned.
- mem_wdata, out, WIDTH, store data.
- mem_rdata, in, WIDTH, read data; sampled only when mem_req & mem_ready.
- mem_ready, in, 1, completes the current transaction in the same cycle.
- gpio_i, in, GPIO_WIDTH, input port read by the IN instruction.
- alu_o, out, WIDTH, ALUOut register.
- pc_o, out, WIDTH, PC register.
- state_o, out, 4, current FSM state code.
- halted, out, 1, high while in HALT.

## Operation

Architectural registers (all reset synchronously):
- PC ← RESET_PC.
- IR, MDR, A, B, ALUOut ← 0.
- Register file: 32 × WIDTH, all entries ← 0.
- r0 always reads 0; writes to r0 are discarded.

Instruction subset:
- R-type (op 0x00), funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - 0x2A slt (signed compare, result 1 or 0).
- lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, j 0x02.
- IN 0x3F: rt ← zero-extended gpio_i.
- Any other op, or an unlisted funct, → HALT.

Arithmetic rules:
- addi, lw, sw, beq sign-extend imm[15:0] to WIDTH.
- ori zero-extends imm[15:0].
- All sums wrap modulo 2^WIDTH; no overflow trap.

FSM states (state_o code):
- FETCH 0: mem_req=1, we=0, addr=PC. On mem_ready: IR ← rdata, PC ← PC+4, go DECODE. Otherwise stay.
- DECODE 1: A ← rs, B ← rt, ALUOut ← PC + (sext(imm)<<2). Dispatch by op:
  - lw/sw → MEMADR 2.
  - R → EXEC 6.
  - beq → BRANCH 8.
  - addi/ori → IMMEX 9.
  - j → JUMP 11.
  - IN → GPIOWB 13.
  - else → HALT 12.
- MEMADR 2: ALUOut ← A + sext(imm). Go MEMRD 3 for lw, MEMWR 5 for sw.
- MEMRD 3: mem_req=1, we=0, addr=ALUOut. On ready: MDR ← rdata, go MEMWB 4.
- MEMWB 4: rt ← MDR, go FETCH.
- MEMWR 5: mem_req=1, we=1, addr=ALUOut, wdata=B. On ready go FETCH.
- EXEC 6: ALUOut ← A op B, go ALUWB 7.
- ALUWB 7: rd ← ALUOut, go FETCH.
- BRANCH 8: if A==B, PC ← ALUOut. Go FETCH.
- IMMEX 9: ALUOut ← A + sext(imm) for addi, A | zext(imm) for ori. Go IMMWB 10.
- IMMWB 10: rt ← ALUOut, go FETCH.
- JUMP 11: PC ← {PC[WIDTH-1:28], IR[25:0], 2'b00}, go FETCH.
- GPIOWB 13: rt ← zext(gpio_i), go FETCH.
- HALT 12: no memory requests; exit only by reset.

Outputs outside memory states: mem_req=0; mem_we, mem_addr and mem_wdata=0.

## Timing

- Reset dominates every condition, including a pending transaction. The cycle after reset: state FETCH, PC=RESET_PC.
- Reset values:
  - mem_req, mem_we, mem_addr, mem_wdata, alu_o, halted = 0.
  - pc_o = RESET_PC, state_o = 0.
  - mem_req is forced to 0 in any cycle with reset=1.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - A transaction completes on the edge where mem_req & mem_ready.
  - No back-to-back request without an intervening state change.
  - mem_ready while mem_req=0 is ignored.
- CPI with mem_ready tied 1:
  - R, addi, ori, sw = 4.
  - lw = 5.
  - beq, j, IN = 3.
  - Each wait cycle adds 1.
- gpio_i is sampled in the GPIOWB cycle; no synchroniser inside this block.
- A write to rt/rd is visible to the next instruction's DECODE.

## Test plan

- Reset, then program with mem_ready=1: `addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1`.
  - Required: r3=2, r4=1.
  - FETCH of the 5th instruction at cycle 16; pc_o=0x10.
- `ori r5,r0,0x8000`.
  - Required: r5=0x00008000 (zero-extended); `addi` with the same imm gives 0xFFFF8000.
- `sw r3,8(r0)` then `lw r6,8(r0)`, with mem_ready low for 2 cycles per transaction.
  - Required: address and data held stable during the wait cycles; one write of 2 to 0x8; r6=2; lw takes 7 cycles.
- beq, taken and not taken, plus a j.
  - Taken beq (offset 3) at 0x20: next fetch at 0x30.
  - Not-taken beq: next fetch at 0x24.
  - j 0x40: next fetch at 0x100.
- gpio_i=0xA5A5, then IN r7.
  - Required: r7=0x0000A5A5 after 3 cycles.
- Illegal op 0x3E.
  - Required: halted=1 and mem_req=0 permanently.
  - Reset asserted mid-FETCH-wait clears halted and returns pc_o to RESET_PC next cycle.
